microcode_sequencer: RTL and testbench

//  Parametrised successor to the fixed 4-bit-step control unit: microcoded sequencer with on-chip

---
 rtl/microcode_sequencer.sv | 137 +++++++++++++
 tb/tb_microcode_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : microcode_sequencer
// Purpose  : Microcoded control sequencer with writable store, memory stall,
//            halt/resume, single-step debug and step-overflow detection.
// Revision : 1.0
// ============================================================================
module microcode_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 8,
    parameter int STEP_WIDTH   = 4,
    parameter int FLAG_WIDTH   = 2,
    parameter int CTRL_WIDTH   = 24,
    parameter int ADDR_WIDTH   = STEP_WIDTH + OPCODE_WIDTH + FLAG_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    prog_en,
    input  logic                    prog_we,
    input  logic [ADDR_WIDTH-1:0]   prog_addr,
    input  logic [CTRL_WIDTH-1:0]   prog_data,
    input  logic                    single_step_mode,
    input  logic                    step_req,
    input  logic                    resume,
    input  logic                    mem_ready,
    input  logic [FLAG_WIDTH-1:0]   alu_flags,
    input  logic [DATA_WIDTH-1:0]   bus_in,
    output logic [CTRL_WIDTH-5:0]   ctrl_out,
    output logic [STEP_WIDTH-1:0]   step,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    halted,
    output logic                    stalled,
    output logic                    err_overflow
);

    localparam int c_BIT_NEXT = 0;
    localparam int c_BIT_LOAD = 1;
    localparam int c_BIT_HALT = 2;
    localparam int c_BIT_WAIT = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SSWAIT = 2'd1,
        ST_HALT   = 2'd2,
        ST_PROG   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [CTRL_WIDTH-5:0]   r_ctrl;
    logic [STEP_WIDTH-1:0]   r_step;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic                    r_stalled;
    logic                    r_err;

    // Store is deliberately left without reset so its contents survive a reset.
    logic [CTRL_WIDTH-1:0]   r_store [0:(2**ADDR_WIDTH)-1];

    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [CTRL_WIDTH-1:0]   w_word;
    logic                    w_exec;
    logic                    w_stall;

    assign w_addr  = {r_step, r_opcode, alu_flags};
    assign w_word  = r_store[w_addr];
    assign w_exec  = (r_state == ST_RUN) || ((r_state == ST_SSWAIT) && step_req);
    assign w_stall = w_word[c_BIT_WAIT] && !mem_ready;

    always_ff @(posedge clock) begin
        if (prog_en && prog_we) begin
            r_store[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_ctrl    <= '0;
            r_step    <= '0;
            r_opcode  <= '0;
            r_stalled <= 1'b0;
            r_err     <= 1'b0;
        end else if (prog_en) begin
            r_state <= ST_PROG;
            r_ctrl  <= '0;
        end else begin
            case (r_state)
                ST_PROG: begin
                    r_state <= ST_RUN;
                end
                ST_HALT: begin
                    r_ctrl <= '0;
                    if (resume) begin
                        r_state <= single_step_mode ? ST_SSWAIT : ST_RUN;
                    end
                end
                default: begin
                    if (w_exec) begin
                        r_ctrl  <= w_word[CTRL_WIDTH-1:4];
                        r_state <= single_step_mode ? ST_SSWAIT : ST_RUN;
                        if (w_stall) begin
                            r_stalled <= 1'b1;
                        end else begin
                            r_stalled <= 1'b0;
                            if (w_word[c_BIT_LOAD]) begin
                                r_opcode <= bus_in[OPCODE_WIDTH-1:0];
                            end
                            if (w_word[c_BIT_HALT]) begin
                                r_step  <= '0;
                                r_ctrl  <= '0;
                                r_state <= ST_HALT;
                            end else if (w_word[c_BIT_NEXT]) begin
                                r_step <= '0;
                            end else begin
                                // Falling off the end of a step sequence is a microcode bug.
                                if (&r_step) begin
                                    r_err <= 1'b1;
                                end
                                r_step <= r_step + 1'b1;
                            end
                        end
                    end else if (!single_step_mode) begin
                        r_state <= ST_RUN;
                    end
                end
            endcase
        end
    end

    assign ctrl_out     = r_ctrl;
    assign step         = r_step;
    assign opcode       = r_opcode;
    assign halted       = (r_state == ST_HALT);
    assign stalled      = r_stalled;
    assign err_overflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_microcode_sequencer
// Purpose  : Directed scoreboard bench for microcode_sequencer.
// Revision : 1.0
// ============================================================================
module tb_microcode_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        prog_en = 1'b0;
    logic        prog_we = 1'b0;
    logic [13:0] prog_addr = '0;
    logic [23:0] prog_data = '0;
    logic        single_step_mode = 1'b0;
    logic        step_req = 1'b0;
    logic        resume = 1'b0;
    logic        mem_ready = 1'b1;
    logic [1:0]  alu_flags = '0;
    logic [7:0]  bus_in = '0;
    logic [19:0] ctrl_out;
    logic [3:0]  step;
    logic [7:0]  opcode;
    logic        halted;
    logic        stalled;
    logic        err_overflow;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [7:0]  op;
        logic [19:0] ct;
        logic        h;
        logic        s;
        logic        e;
    } exp_t;

    exp_t exp_q[$];

    microcode_sequencer dut (
        .clock(clock), .reset(reset), .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .single_step_mode(single_step_mode), .step_req(step_req), .resume(resume),
        .mem_ready(mem_ready), .alu_flags(alu_flags), .bus_in(bus_in),
        .ctrl_out(ctrl_out), .step(step), .opcode(opcode), .halted(halted),
        .stalled(stalled), .err_overflow(err_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] st, input logic [7:0] op,
                        input logic [19:0] ct, input logic h, input logic s, input logic e);
        exp_t x;
        x.tag = tag; x.st = st; x.op = op; x.ct = ct; x.h = h; x.s = s; x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic compare_all();
        exp_t x;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk(x.tag, "step",    {28'd0, step},    {28'd0, x.st});
            chk(x.tag, "opcode",  {24'd0, opcode},  {24'd0, x.op});
            chk(x.tag, "ctrl",    {12'd0, ctrl_out}, {12'd0, x.ct});
            chk(x.tag, "halted",  {31'd0, halted},  {31'd0, x.h});
            chk(x.tag, "stalled", {31'd0, stalled}, {31'd0, x.s});
            chk(x.tag, "err",     {31'd0, err_overflow}, {31'd0, x.e});
        end
    endtask

    // Push the expectation for the coming edge, then sample 1 time unit after it.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [7:0] op,
                       input logic [19:0] ct, input logic h, input logic s, input logic e);
        push(tag, st, op, ct, h, s, e);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic pwrite(input logic [3:0] st, input logic [7:0] op, input logic [23:0] d);
        prog_en   = 1'b1;
        prog_we   = 1'b1;
        prog_addr = {st, op, 2'b00};
        prog_data = d;
        @(posedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        #2 reset = 1'b1;

        // Store is programmed while the sequencer is held in reset.
        push("reset_state", 4'd0, 8'h00, 20'h0, 1'b0, 1'b0, 1'b0);
        pwrite(4'd0, 8'h00, 24'h000A52);
        pwrite(4'd1, 8'h12, 24'h000111);
        pwrite(4'd0, 8'h12, 24'h00033A);
        pwrite(4'd1, 8'h34, 24'h000774);
        pwrite(4'd0, 8'h34, 24'h000552);
        for (int s = 0; s < 16; s++) begin
            pwrite(4'(s), 8'h56, 24'h001000 + 24'(s * 16));
        end
        push("reset_held", 4'd0, 8'h00, 20'h0, 1'b0, 1'b0, 1'b0);
        compare_all();
        prog_en = 1'b0;
        prog_we = 1'b0;
        reset   = 1'b0;

        // Fetch: LOAD opcode 0x12, then NEXT returns step to 0.
        bus_in = 8'h12;
        cyc("fetch_load", 4'd1, 8'h12, 20'h000A5, 1'b0, 1'b0, 1'b0);
        bus_in = 8'h77;
        cyc("fetch_next", 4'd0, 8'h12, 20'h00011, 1'b0, 1'b0, 1'b0);

        // WAIT+LOAD word stalls while memory is not ready; LOAD must not fire.
        mem_ready = 1'b0;
        bus_in    = 8'h99;
        for (int i = 0; i < 3; i++) begin
            cyc("stall", 4'd0, 8'h12, 20'h00033, 1'b0, 1'b1, 1'b0);
        end
        mem_ready = 1'b1;
        bus_in    = 8'h34;
        cyc("stall_release", 4'd1, 8'h34, 20'h00033, 1'b0, 1'b0, 1'b0);

        // HALT word, hold, then resume.
        cyc("halt_enter", 4'd0, 8'h34, 20'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc("halt_hold", 4'd0, 8'h34, 20'h0, 1'b1, 1'b0, 1'b0);
        end
        resume = 1'b1;
        cyc("resume", 4'd0, 8'h34, 20'h0, 1'b0, 1'b0, 1'b0);
        resume = 1'b0;
        bus_in = 8'h56;
        single_step_mode = 1'b1;
        cyc("post_resume_exec", 4'd1, 8'h56, 20'h00055, 1'b0, 1'b0, 1'b0);

        // Single-step: exactly one advance per step_req pulse.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                cyc("ss_idle", 4'(1 + p), 8'h56, (p == 0) ? 20'h00055 : 20'h00101, 1'b0, 1'b0, 1'b0);
            end
            step_req = 1'b1;
            cyc("ss_pulse", 4'(2 + p), 8'h56, 20'h00100 + 20'(1 + p), 1'b0, 1'b0, 1'b0);
            step_req = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            cyc("ss_idle2", 4'd3, 8'h56, 20'h00102, 1'b0, 1'b0, 1'b0);
        end
        single_step_mode = 1'b0;
        cyc("ss_exit", 4'd3, 8'h56, 20'h00102, 1'b0, 1'b0, 1'b0);

        // Run off the end of the step range: wrap sets sticky overflow.
        for (int s = 3; s < 16; s++) begin
            cyc("run_wrap", 4'(s + 1), 8'h56, 20'h00100 + 20'(s), 1'b0, 1'b0, (s == 15) ? 1'b1 : 1'b0);
        end
        cyc("err_sticky", 4'd1, 8'h56, 20'h00100, 1'b0, 1'b0, 1'b1);

        // Programming mid-run freezes step/opcode and zeroes ctrl_out.
        pwrite(4'd2, 8'h56, 24'h001AA0);
        push("prog_freeze", 4'd1, 8'h56, 20'h0, 1'b0, 1'b0, 1'b1);
        compare_all();
        prog_en = 1'b0;
        prog_we = 1'b0;
        cyc("prog_exit", 4'd1, 8'h56, 20'h0, 1'b0, 1'b0, 1'b1);
        cyc("run_after_prog", 4'd2, 8'h56, 20'h00101, 1'b0, 1'b0, 1'b1);
        cyc("new_word", 4'd3, 8'h56, 20'h001AA, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset takes effect without a clock edge.
        reset = 1'b1;
        #1;
        push("async_reset", 4'd0, 8'h00, 20'h0, 1'b0, 1'b0, 1'b0);
        compare_all();
        #10;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
